// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of the single 256-bit
// data-memory port. Port 0 is the instruction-cache refill path, port 1 is
// dcache_top. One transaction is latched, driven to memory until mem_ack_i,
// and the acknowledge is routed back to its owner. A sticky watchdog flag
// reports transactions that sit in BUSY too long without an acknowledge.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit
  // wide so the declaration stays legal in that case.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic             last_served;
  logic [CNT_W-1:0] busy_cnt;
  logic             pick_m1;

  // Round-robin choice: a lone requester wins, a tie goes to the port that
  // was not served last.
  always_comb begin
    pick_m1 = m1_enable_i && (!m0_enable_i || !last_served);
  end

  // Only the acknowledge and the read data are combinational paths; grant_o
  // is nonzero only in BUSY, so the ack is suppressed in IDLE and DONE.
  assign m0_ack_o  = mem_ack_i & grant_o[0];
  assign m1_ack_o  = mem_ack_i & grant_o[1];
  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

  // Arbiter FSM: the memory-side outputs double as the latched transaction
  // registers, so they stay stable for the whole BUSY phase.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      last_served  <= 1'b0;
      busy_cnt     <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      grant_o      <= 2'b00;
      timeout_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_enable_i || m1_enable_i) begin
            last_served  <= pick_m1;
            busy_cnt     <= '0;
            mem_enable_o <= 1'b1;
            if (pick_m1) begin
              mem_write_o <= m1_write_i;
              mem_addr_o  <= m1_addr_i;
              mem_data_o  <= m1_data_i;
              grant_o     <= 2'b10;
            end else begin
              mem_write_o <= m0_write_i;
              mem_addr_o  <= m0_addr_i;
              mem_data_o  <= m0_data_i;
              grant_o     <= 2'b01;
            end
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            grant_o      <= 2'b00;
            state        <= DONE;
          end else if ((TIMEOUT != 0) && (busy_cnt != CNT_MAX)) begin
            busy_cnt <= busy_cnt + 1'b1;
            if (busy_cnt == CNT_MAX - 1'b1) begin
              timeout_o <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single 256-bit off-chip data-memory port between the instruction-cache refill path (port 0) and `dcache_top` (port 1). It sits between both cache controllers and the memory model, at the level of the `CPU` top. It latches one requester's transaction, drives it to memory until `mem_ack_i`, and routes the acknowledge and read data back to that requester. It also provides a sticky watchdog flag for transactions that are never acknowledged.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 256, cache-line data width
- `TIMEOUT`, 255, BUSY cycles without ack before `timeout_o` sets; 0 disables the watchdog

Ports:
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `m0_enable_i`  in  1  port 0 request; held until `m0_ack_o`
- `m0_write_i`  in  1  port 0: 1 = write, 0 = read
- `m0_addr_i`  in  ADDR_W  port 0 line address
- `m0_data_i`  in  DATA_W  port 0 write data
- `m0_ack_o`  out  1  port 0 completion pulse
- `m0_data_o`  out  DATA_W  port 0 read data; valid with `m0_ack_o`
- `m1_enable_i`, `m1_write_i`, `m1_addr_i`, `m1_data_i`, `m1_ack_o`, `m1_data_o`  same for port 1 (dcache)
- `mem_data_i`  in  DATA_W  memory read data
- `mem_ack_i`  in  1  memory completion pulse
- `mem_enable_o`  out  1  memory request
- `mem_write_o`  out  1  memory write strobe
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_data_o`  out  DATA_W  memory write data
- `grant_o`  out  2  one-hot current owner, 00 when no transaction is in progress
- `timeout_o`  out  1  sticky watchdog flag

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE:**
  - If any `mN_enable_i` is set, select a winner, latch its write, addr and data into internal registers, set `grant_o`, and go to BUSY.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - A single requester wins outright.
  - If both request, the port that is not `last_served` wins.
  - `last_served` updates at grant. Its reset value is 0, so port 1 (dcache) wins the first tie.
- **BUSY:**
  - `mem_enable_o` = 1. `mem_write_o`, `mem_addr_o` and `mem_data_o` come from the latched registers and stay stable for the whole transaction.
  - When `mem_ack_i` = 1, `ack_o` of the granted port equals `mem_ack_i` combinationally in the same cycle, and the FSM goes to DONE.
- **DONE:**
  - Lasts exactly one cycle, with `mem_enable_o` = 0 and `grant_o` = 00.
  - This gives the requester one cycle to drop its enable. The next state is IDLE.
- **Read data:** `m0_data_o` and `m1_data_o` both equal `mem_data_i` at all times. Each is meaningful only while its own ack is high.
- **Ignored events:**
  - `mem_ack_i` in IDLE or DONE is ignored; no ack is forwarded.
  - A requester dropping enable during BUSY does not abort the transaction. It completes, and the ack is still pulsed.
- **Watchdog:**
  - The BUSY cycle counter is `$clog2(TIMEOUT+1)` bits wide. It clears on entry to BUSY and saturates.
  - When the count reaches `TIMEOUT` with no ack, `timeout_o` sets. The FSM keeps waiting in BUSY.
  - `timeout_o` clears only on reset.

## Timing
- **Reset values:** state = IDLE, `last_served` = 0, counter = 0. All outputs are 0, except that `mN_data_o` follows `mem_data_i`. Assertion takes effect immediately (asynchronous). A reset during BUSY drops `mem_enable_o` in the same cycle and abandons the transaction without an ack.
- **Grant latency:** enable sampled at edge t in IDLE → `mem_enable_o` = 1 from t+1.
- **Completion:** `mem_ack_i` high in cycle k (BUSY) → granted ack high in cycle k → DONE in k+1 → IDLE in k+2. The earliest next grant is at the edge ending k+2, so memory is busy from k+3.
- **Back-to-back:**
  - With both ports continuously requesting, grants alternate 1,0,1,0…
  - The minimum idle gap on `mem_enable_o` between transactions is 2 cycles (DONE + IDLE).
- **Watchdog timing:** `timeout_o` rises on the edge where the counter reaches `TIMEOUT`, i.e. the `TIMEOUT`-th BUSY cycle without ack. It is never set when `TIMEOUT` = 0.
- **No combinational path** runs from `mN_*_i` to `mem_*_o`. Only `mem_ack_i` → `mN_ack_o` and `mem_data_i` → `mN_data_o` are combinational.

## Test plan
- **Reset:** hold `rst_i` = 0 with both enables high → all outputs 0, no grant. Release → port 1 is granted (`grant_o` = 10) and `mem_enable_o` is 1 one cycle later.
- **Single read on port 0:** addr 0x400, memory ack 10 cycles after enable, `mem_data_i` = 256'hA5…A5 → `m0_ack_o` is a one-cycle pulse coincident with `mem_ack_i`, `m0_data_o` = A5…A5, `m1_ack_o` stays 0, `grant_o` returns to 00.
- **Contention:** both ports request continuously for 4 transactions → grant order 1,0,1,0. Each `mem_addr_o` matches its owner's address, and there is a 2-cycle enable gap between transactions.
- **Stability:** port 1 write to 0x800 with data D; after the grant, change `m1_addr_i` and `m1_data_i` and drop enable → memory still sees 0x800/D with write = 1 until ack, and `m1_ack_o` pulses.
- **Spurious ack:** pulse `mem_ack_i` in IDLE and in DONE → no `mN_ack_o`, no state change.
- **Watchdog and reset mid-transaction:**
  - With `TIMEOUT` = 8 and ack withheld → `timeout_o` rises after 8 BUSY cycles and stays high after a later ack.
  - Asserting `rst_i` mid-BUSY → `mem_enable_o` drops immediately and `timeout_o` clears.
